// File: rtl/ibex_instr_mem_responder.sv
// Word-addressed SRAM responder for the instruction fetch bus.
// Reads at the grant edge and returns {valid, err, data} in order through a fixed-latency shift pipeline.
module ibex_instr_mem_responder #(
  parameter int unsigned MemWords = 1024,
  parameter logic [31:0] BaseAddr = 32'h0010_0000,
  parameter int unsigned RspDelay = 1,
  parameter int unsigned MaxOutst = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,
  input  logic        stall_i,
  input  logic        wr_en_i,
  input  logic [31:0] wr_addr_i,
  input  logic [31:0] wr_data_i
);

  localparam int unsigned AddrW     = $clog2(MemWords);
  localparam int unsigned CntW      = $clog2(MaxOutst + 1);
  localparam logic [31:0] SpanBytes = 32'(MemWords * 4);
  localparam logic [CntW-1:0] MaxCnt = CntW'(MaxOutst);

  logic [31:0]     mem_q [MemWords];
  logic [CntW-1:0] outst_q, outst_d;
  logic [RspDelay-1:0] valid_q;
  logic [RspDelay-1:0] err_q;
  logic [31:0]     data_q [RspDelay];

  logic             grant;
  logic             fetch_err;
  logic [AddrW-1:0] fetch_idx;
  logic             wr_err;
  logic [AddrW-1:0] wr_idx;
  logic             resp_retire;

  // Offsets below BaseAddr wrap to huge values and fall out of range naturally.
  function automatic logic addr_err(input logic [31:0] addr);
    logic [31:0] offset;
    offset = addr - BaseAddr;
    return (addr[1:0] != 2'b00) || (offset >= SpanBytes);
  endfunction

  function automatic logic [AddrW-1:0] addr_idx(input logic [31:0] addr);
    logic [31:0] offset;
    offset = addr - BaseAddr;
    return offset[AddrW+1:2];
  endfunction

  assign fetch_err   = addr_err(instr_addr_i);
  assign fetch_idx   = addr_idx(instr_addr_i);
  assign wr_err      = addr_err(wr_addr_i);
  assign wr_idx      = addr_idx(wr_addr_i);

  assign instr_gnt_o = rst_ni & instr_req_i & ~stall_i & (outst_q < MaxCnt);
  assign grant       = instr_req_i & instr_gnt_o;

  // A response is retired from the count on the edge that makes it visible on rvalid.
  generate
    if (RspDelay == 1) begin : g_retire_direct
      assign resp_retire = grant;
    end else begin : g_retire_pipe
      assign resp_retire = valid_q[RspDelay-2];
    end
  endgenerate

  always_comb begin
    outst_d = outst_q + CntW'(grant) - CntW'(resp_retire);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      outst_q <= '0;
      valid_q <= '0;
      err_q   <= '0;
      for (int i = 0; i < RspDelay; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      outst_q   <= outst_d;
      valid_q[0] <= grant;
      err_q[0]   <= grant & fetch_err;
      data_q[0]  <= (grant && !fetch_err) ? mem_q[fetch_idx] : 32'h0;
      for (int i = 1; i < RspDelay; i++) begin
        valid_q[i] <= valid_q[i-1];
        err_q[i]   <= err_q[i-1];
        data_q[i]  <= data_q[i-1];
      end
    end
  end

  // Loader port; the fetch above samples mem_q before this write lands (read-first).
  always_ff @(posedge clk_i) begin
    if (wr_en_i && !wr_err) begin
      mem_q[wr_idx] <= wr_data_i;
    end
  end

  assign instr_rvalid_o = valid_q[RspDelay-1];
  assign instr_err_o    = err_q[RspDelay-1];
  assign instr_rdata_o  = data_q[RspDelay-1];

  assert property (@(posedge clk_i) disable iff (!rst_ni) instr_err_o |-> instr_rvalid_o);
  assert property (@(posedge clk_i) disable iff (!rst_ni) outst_q <= MaxCnt);
  assert property (@(posedge clk_i) disable iff (!rst_ni)
                   instr_rvalid_o |-> $past(instr_req_i & instr_gnt_o, RspDelay));

endmodule

// File: tb/tb_ibex_instr_mem_responder.sv
// Bench for ibex_instr_mem_responder: a queue-based reference model checked every cycle,
// directed scenarios pinned with literal expectations, then a randomized phase.
module tb_ibex_instr_mem_responder;

  localparam int unsigned MemWords = 64;
  localparam logic [31:0] BaseAddr = 32'h0010_0000;
  localparam int unsigned RspDelay = 3;
  localparam int unsigned MaxOutst = 2;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic        req = 1'b0;
  logic [31:0] addr = '0;
  logic        stall = 1'b0;
  logic        wrEn = 1'b0;
  logic [31:0] wrAddr = '0;
  logic [31:0] wrData = '0;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  always #5 clk = ~clk;

  ibex_instr_mem_responder #(
    .MemWords(MemWords),
    .BaseAddr(BaseAddr),
    .RspDelay(RspDelay),
    .MaxOutst(MaxOutst)
  ) dut (
    .clk_i(clk),
    .rst_ni(rstN),
    .instr_req_i(req),
    .instr_addr_i(addr),
    .instr_gnt_o(gnt),
    .instr_rvalid_o(rvalid),
    .instr_rdata_o(rdata),
    .instr_err_o(err),
    .stall_i(stall),
    .wr_en_i(wrEn),
    .wr_addr_i(wrAddr),
    .wr_data_i(wrData)
  );

  typedef struct {
    int          due;
    bit          err;
    logic [31:0] data;
  } rsp_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  bit          modelGnt = 1'b0;
  bit   [31:0] refMem [MemWords];
  rsp_t        pending [$];
  rsp_t        rspLog [$];
  int          gntLog [$];
  logic [31:0] bootWords [4] = '{32'h0000_0013, 32'h0010_0093, 32'h0020_0113, 32'h0030_0193};

  function automatic bit refErr(input logic [31:0] a);
    longint unsigned lo, hi;
    lo = longint'(BaseAddr);
    hi = lo + 4 * MemWords;
    return (a % 4 != 0) || (longint'(a) < lo) || (longint'(a) >= hi);
  endfunction

  function automatic int refIdx(input logic [31:0] a);
    return int'((a - BaseAddr) / 4);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s cycle=%0d actual=%h expected=%h", name, cyc, actual, expected);
    end
  endtask

  task automatic applyStimulus(input bit r, input logic [31:0] a, input bit s,
                               input bit we, input logic [31:0] wa, input logic [31:0] wd);
    @(posedge clk);
    #1;
    req    = r;
    addr   = a;
    stall  = s;
    wrEn   = we;
    wrAddr = wa;
    wrData = wd;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 32'h0, 0, 0, 32'h0, 32'h0);
  endtask

  task automatic fetchWord(input logic [31:0] a);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      applyStimulus(1, a, 0, 0, 32'h0, 32'h0);
      @(negedge clk);
      #1;
      done = modelGnt;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL grant_timeout addr=%h actual=no_grant expected=grant", a);
    end
  endtask

  // Reference: a grant at cycle g is visible at cycle g+RspDelay; outstanding = responses not yet visible.
  initial begin
    forever begin
      bit          expValid;
      bit          expErr;
      logic [31:0] expData;
      @(negedge clk);
      expValid = 1'b0;
      expErr   = 1'b0;
      expData  = 32'h0;
      if (!rstN) begin
        pending.delete();
      end else if (pending.size() > 0 && pending[0].due == cyc) begin
        expValid = 1'b1;
        expErr   = pending[0].err;
        expData  = pending[0].data;
        rspLog.push_back(pending[0]);
        void'(pending.pop_front());
      end
      modelGnt = rstN && req && !stall && (pending.size() < MaxOutst);
      checkOutput("gnt", 32'(gnt), 32'(modelGnt));
      checkOutput("rvalid", 32'(rvalid), 32'(expValid));
      checkOutput("err", 32'(err), 32'(expErr));
      checkOutput("rdata", rdata, expData);
      if (modelGnt) begin
        rsp_t r;
        r.due  = cyc + RspDelay;
        r.err  = refErr(addr);
        r.data = r.err ? 32'h0 : refMem[refIdx(addr)];
        pending.push_back(r);
        gntLog.push_back(cyc);
      end
      if (wrEn && !refErr(wrAddr)) refMem[refIdx(wrAddr)] = wrData;
      cyc++;
    end
  end

  initial begin
    int startCyc;
    int expOffs [6] = '{0, 1, 3, 4, 6, 7};
    repeat (3) @(posedge clk);
    #1 rstN = 1'b1;

    for (int i = 0; i < MemWords; i++) begin
      logic [31:0] d;
      d = (i < 4) ? bootWords[i] : (i == 4) ? 32'h0 : (i == 9) ? 32'hCAFE_0009 : $urandom;
      applyStimulus(0, 32'h0, 0, 1, BaseAddr + 32'(4 * i), d);
    end
    idle(RspDelay + 2);

    rspLog.delete();
    for (int i = 0; i < 4; i++) fetchWord(BaseAddr + 32'(4 * i));
    idle(RspDelay + 2);
    checkOutput("boot_count", rspLog.size(), 4);
    for (int i = 0; i < 4 && i < rspLog.size(); i++) begin
      checkOutput("boot_data", rspLog[i].data, bootWords[i]);
      checkOutput("boot_err", 32'(rspLog[i].err), 0);
    end

    rspLog.delete();
    fetchWord(32'h0010_0002);
    fetchWord(32'h0010_0100);
    idle(RspDelay + 2);
    checkOutput("err_count", rspLog.size(), 2);
    for (int i = 0; i < 2 && i < rspLog.size(); i++) begin
      checkOutput("err_flag", 32'(rspLog[i].err), 1);
      checkOutput("err_data", rspLog[i].data, 32'h0);
    end

    gntLog.delete();
    applyStimulus(1, BaseAddr + 32'h20, 0, 0, 32'h0, 32'h0);
    startCyc = cyc;
    for (int i = 1; i < 8; i++) applyStimulus(1, BaseAddr + 32'h20, 0, 0, 32'h0, 32'h0);
    idle(RspDelay + 2);
    checkOutput("throttle_count", gntLog.size(), 6);
    for (int i = 0; i < 6 && i < gntLog.size(); i++)
      checkOutput("throttle_cycle", gntLog[i] - startCyc, expOffs[i]);

    rspLog.delete();
    gntLog.delete();
    applyStimulus(1, BaseAddr + 32'h24, 1, 0, 32'h0, 32'h0);
    startCyc = cyc;
    for (int i = 1; i < 5; i++) applyStimulus(1, BaseAddr + 32'h24, 1, 0, 32'h0, 32'h0);
    fetchWord(BaseAddr + 32'h24);
    idle(RspDelay + 2);
    checkOutput("stall_grants", gntLog.size(), 1);
    if (gntLog.size() > 0) checkOutput("stall_release", gntLog[0] - startCyc, 5);
    if (rspLog.size() > 0) checkOutput("stall_data", rspLog[0].data, 32'hCAFE_0009);

    rspLog.delete();
    gntLog.delete();
    applyStimulus(1, BaseAddr + 32'h10, 0, 1, BaseAddr + 32'h10, 32'hDEAD_BEEF);
    idle(1);
    fetchWord(BaseAddr + 32'h10);
    idle(RspDelay + 2);
    checkOutput("rw_grants", gntLog.size(), 2);
    checkOutput("rw_count", rspLog.size(), 2);
    if (rspLog.size() == 2) begin
      checkOutput("rw_old", rspLog[0].data, 32'h0);
      checkOutput("rw_new", rspLog[1].data, 32'hDEAD_BEEF);
    end

    rspLog.delete();
    fetchWord(BaseAddr + 32'h4);
    @(posedge clk);
    #1;
    rstN = 1'b0;
    req  = 1'b1;
    addr = BaseAddr;
    @(posedge clk);
    #1;
    rstN = 1'b1;
    req  = 1'b0;
    idle(RspDelay + 3);
    checkOutput("reset_drop", rspLog.size(), 0);
    fetchWord(BaseAddr + 32'hC);
    idle(RspDelay + 2);
    checkOutput("reset_resume", rspLog.size(), 1);
    if (rspLog.size() > 0) checkOutput("reset_data", rspLog[0].data, 32'h0030_0193);

    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      logic [31:0] wa;
      int          k;
      k = $urandom_range(0, 9);
      a = BaseAddr + 32'($urandom_range(0, MemWords - 1) * 4);
      if (k == 7) a = a | 32'($urandom_range(1, 3));
      if (k == 8) a = BaseAddr + 32'(4 * MemWords) + 32'($urandom_range(0, 3) * 4);
      if (k == 9) a = BaseAddr - 32'(4 * $urandom_range(1, 4));
      wa = BaseAddr + 32'($urandom_range(0, MemWords) * 4) + 32'($urandom_range(0, 9) == 0);
      applyStimulus($urandom_range(0, 9) < 7, a, $urandom_range(0, 4) == 0,
                    $urandom_range(0, 4) == 0, wa, $urandom);
    end
    idle(RspDelay + 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
